// File: rtl/cp0_exc_ctrl_if.sv
// Pipeline <-> CP0 exception controller signal bundle.
// master = pipeline side, slave = cp0_exc_ctrl.
interface cp0_exc_ctrl_if #(parameter int HW_INT_NUM = 6);
  logic [HW_INT_NUM-1:0] hw_int;
  logic                  mem_valid;
  logic                  exc_req;
  logic [4:0]            exc_code;
  logic                  exc_bd;
  logic                  exc_badvaddr_en;
  logic [31:0]           exc_badvaddr;
  logic [31:0]           mem_pc;
  logic                  eret;
  logic                  mtc0_en;
  logic [4:0]            cp0_addr;
  logic [31:0]           cp0_wdata;
  logic [31:0]           cp0_rdata;
  logic                  int_pending;
  logic                  flush;
  logic [31:0]           flush_pc;

  modport master (
    output hw_int, mem_valid, exc_req, exc_code, exc_bd, exc_badvaddr_en,
           exc_badvaddr, mem_pc, eret, mtc0_en, cp0_addr, cp0_wdata,
    input  cp0_rdata, int_pending, flush, flush_pc
  );

  modport slave (
    input  hw_int, mem_valid, exc_req, exc_code, exc_bd, exc_badvaddr_en,
           exc_badvaddr, mem_pc, eret, mtc0_en, cp0_addr, cp0_wdata,
    output cp0_rdata, int_pending, flush, flush_pc
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: Status, Cause, EPC, BadVAddr, ERET/flush.
// Define CP0_TIMER_EN to add Count/Compare with a prescaled timer interrupt (TI).
module cp0_exc_ctrl #(
  parameter int          HW_INT_NUM = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic          clk,
  input  logic          resetn,
  cp0_exc_ctrl_if.slave bus
);
  logic [HW_INT_NUM-1:0] hw_s1_q, hw_s2_q;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d, bva_q, bva_d;
  logic [31:0] count_rd, compare_rd;
  logic [7:0]  ip;
  logic        ti, int_pend, exc_take, eret_take, wr_en;

  always_comb begin
    ip = '0;
    ip[1:0] = ip_sw_q;
    for (int i = 0; i < HW_INT_NUM; i++) ip[i+2] = hw_s2_q[i];
    // IP7 is shared between the top hardware line and the timer
    ip[7] = ip[7] | ti;
  end

  assign int_pend  = (|(ip & im_q)) & ie_q & ~exl_q;
  assign exc_take  = bus.mem_valid & (bus.exc_req | int_pend);
  assign eret_take = bus.mem_valid & bus.eret & ~exc_take;
  assign wr_en     = bus.mem_valid & bus.mtc0_en & ~exc_take;

  assign bus.int_pending = int_pend;
  assign bus.flush       = resetn & (exc_take | (bus.mem_valid & bus.eret));
  assign bus.flush_pc    = exc_take ? EXC_VECTOR : epc_q;

  always_comb begin
    im_d = im_q; exl_d = exl_q; ie_d = ie_q; bd_d = bd_q;
    ip_sw_d = ip_sw_q; code_d = code_q; epc_d = epc_q; bva_d = bva_q;
    if (exc_take) begin
      // nested exceptions keep the original return point
      if (!exl_q) begin
        epc_d = bus.exc_bd ? bus.mem_pc - 32'd4 : bus.mem_pc;
        bd_d  = bus.exc_bd;
      end
      exl_d  = 1'b1;
      code_d = int_pend ? 5'd0 : bus.exc_code;
      if (bus.exc_badvaddr_en) bva_d = bus.exc_badvaddr;
    end else begin
      if (eret_take) exl_d = 1'b0;
      if (wr_en) begin
        case (bus.cp0_addr)
          5'd12: begin
            im_d  = bus.cp0_wdata[15:8];
            exl_d = bus.cp0_wdata[1];
            ie_d  = bus.cp0_wdata[0];
          end
          5'd13:   ip_sw_d = bus.cp0_wdata[9:8];
          5'd14:   epc_d   = bus.cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hw_s1_q <= '0; hw_s2_q <= '0;
      im_q <= '0; exl_q <= 1'b0; ie_q <= 1'b0; bd_q <= 1'b0;
      ip_sw_q <= '0; code_q <= '0; epc_q <= '0; bva_q <= '0;
    end else begin
      hw_s1_q <= bus.hw_int; hw_s2_q <= hw_s1_q;
      im_q <= im_d; exl_q <= exl_d; ie_q <= ie_d; bd_q <= bd_d;
      ip_sw_q <= ip_sw_d; code_q <= code_d; epc_q <= epc_d; bva_q <= bva_d;
    end
  end

`ifdef CP0_TIMER_EN
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  logic [31:0]   count_q, count_d, compare_q, compare_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ti_q, ti_d, tick;

  assign tick = (presc_q == PW'(COUNT_DIV - 1));

  always_comb begin
    count_d = count_q; compare_d = compare_q; presc_d = presc_q; ti_d = ti_q;
    if (wr_en && bus.cp0_addr == 5'd9) begin
      count_d = bus.cp0_wdata;
      presc_d = '0;
    end else if (tick) begin
      if (count_q == compare_q) ti_d = 1'b1;
      count_d = count_q + 32'd1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    // Compare write acknowledges the timer; it wins over a same-cycle match
    if (wr_en && bus.cp0_addr == 5'd11) begin
      compare_d = bus.cp0_wdata;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0; compare_q <= '0; presc_q <= '0; ti_q <= 1'b0;
    end else begin
      count_q <= count_d; compare_q <= compare_d; presc_q <= presc_d; ti_q <= ti_d;
    end
  end

  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  logic unused_count_div;
  assign unused_count_div = (COUNT_DIV > 0);
  assign ti         = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_addr)
      5'd8:  bus.cp0_rdata = bva_q;
      5'd9:  bus.cp0_rdata = count_rd;
      5'd11: bus.cp0_rdata = compare_rd;
      5'd12: bus.cp0_rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
      5'd13: bus.cp0_rdata = {bd_q, ti, 14'b0, ip, 1'b0, code_q, 2'b0};
      5'd14: bus.cp0_rdata = epc_q;
      default: ;
    endcase
  end
endmodule
